// File: rtl/request_unit.sv
// ============================================================================
//  Module      : request_unit
//  Description : Arbitrates instruction-fetch and data-access requests onto a
//                single RAM port. Data has priority over fetch; responses are
//                registered and held. Optional wait timeout via REQ_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module request_unit #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              nRST,
    // instruction fetch port
    input  logic              imem_req,
    input  logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_load,
    output logic              i_ready,
    // data access port
    input  logic              dmem_ren,
    input  logic              dmem_wen,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_store,
    output logic [DATA_W-1:0] dmem_load,
    output logic              d_ready,
    // shared RAM port
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_store,
    output logic              ram_ren,
    output logic              ram_wen,
    input  logic [DATA_W-1:0] ram_load,
    input  logic              ram_ack,
    output logic              bus_err
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_IFETCH  = 2'd1;
    localparam logic [1:0] c_DACCESS = 2'd2;
    localparam logic [1:0] c_RESP    = 2'd3;

    if (TIMEOUT < 1) begin : g_timeout_check
        $error("request_unit: TIMEOUT must be >= 1");
    end

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_is_write;
    logic              r_is_data;
    logic              r_err;
    logic [DATA_W-1:0] r_imem_load;
    logic [DATA_W-1:0] r_dmem_load;
    logic              w_busy;
    logic              w_dreq;
    logic              w_timeout;

    assign w_busy = (r_state == c_IFETCH) || (r_state == c_DACCESS);
    assign w_dreq = dmem_wen || dmem_ren;

`ifdef REQ_TIMEOUT_EN
    localparam int              c_CNT_W       = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_CNT = c_CNT_W'(TIMEOUT);

    logic [c_CNT_W-1:0] r_wait_cnt;

    // Counter sits at zero outside an access so every access starts fresh.
    always_ff @(posedge clk) begin
        if (!nRST) begin
            r_wait_cnt <= '0;
        end else if (!w_busy) begin
            r_wait_cnt <= '0;
        end else if (!ram_ack && (r_wait_cnt != c_TIMEOUT_CNT)) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // An ack on the limit cycle takes precedence over the abort.
    assign w_timeout = w_busy && !ram_ack && (r_wait_cnt == c_TIMEOUT_CNT);
    assign bus_err   = (r_state == c_RESP) && r_err;
`else
    assign w_timeout = 1'b0;
    assign bus_err   = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!nRST) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_dreq) begin
                    w_next_state = c_DACCESS;
                end else if (imem_req) begin
                    w_next_state = c_IFETCH;
                end
            end
            c_IFETCH, c_DACCESS: begin
                if (ram_ack || w_timeout) begin
                    w_next_state = c_RESP;
                end
            end
            c_RESP: begin
                w_next_state = c_IDLE;
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    // Output logic: RAM side is quiet outside the two access states.
    always_comb begin
        ram_addr  = '0;
        ram_store = '0;
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        i_ready   = 1'b0;
        d_ready   = 1'b0;
        case (r_state)
            c_IFETCH: begin
                ram_addr = r_addr;
                ram_ren  = 1'b1;
            end
            c_DACCESS: begin
                ram_addr = r_addr;
                if (r_is_write) begin
                    ram_store = r_data;
                    ram_wen   = 1'b1;
                end else begin
                    ram_ren   = 1'b1;
                end
            end
            c_RESP: begin
                i_ready = !r_is_data;
                d_ready = r_is_data;
            end
            default: begin
            end
        endcase
    end

    // Request latching and response capture
    always_ff @(posedge clk) begin
        if (!nRST) begin
            r_addr      <= '0;
            r_data      <= '0;
            r_is_write  <= 1'b0;
            r_is_data   <= 1'b0;
            r_err       <= 1'b0;
            r_imem_load <= '0;
            r_dmem_load <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_err <= 1'b0;
                    if (w_dreq) begin
                        r_addr     <= dmem_addr;
                        r_data     <= dmem_wen ? dmem_store : '0;
                        r_is_write <= dmem_wen;
                        r_is_data  <= 1'b1;
                    end else if (imem_req) begin
                        r_addr     <= imem_addr;
                        r_data     <= '0;
                        r_is_write <= 1'b0;
                        r_is_data  <= 1'b0;
                    end
                end
                c_IFETCH, c_DACCESS: begin
                    if (ram_ack) begin
                        if (!r_is_data) begin
                            r_imem_load <= ram_load;
                        end else if (!r_is_write) begin
                            r_dmem_load <= ram_load;
                        end
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                        if (!r_is_data) begin
                            r_imem_load <= '0;
                        end else if (!r_is_write) begin
                            r_dmem_load <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign imem_load = r_imem_load;
    assign dmem_load = r_dmem_load;

endmodule

`default_nettype wire

// File: tb/tb_request_unit.sv
// ============================================================================
//  Module      : tb_request_unit
//  Description : Directed self-checking bench for request_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_request_unit;

    logic        clk = 1'b0;
    logic        nRST;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_load;
    logic        i_ready;
    logic        dmem_ren;
    logic        dmem_wen;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_store;
    logic [31:0] dmem_load;
    logic        d_ready;
    logic [31:0] ram_addr;
    logic [31:0] ram_store;
    logic        ram_ren;
    logic        ram_wen;
    logic [31:0] ram_load;
    logic        ram_ack;
    logic        bus_err;

    int n_checks = 0;
    int n_errors = 0;

    request_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk        (clk),
        .nRST       (nRST),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_load  (imem_load),
        .i_ready    (i_ready),
        .dmem_ren   (dmem_ren),
        .dmem_wen   (dmem_wen),
        .dmem_addr  (dmem_addr),
        .dmem_store (dmem_store),
        .dmem_load  (dmem_load),
        .d_ready    (d_ready),
        .ram_addr   (ram_addr),
        .ram_store  (ram_store),
        .ram_ren    (ram_ren),
        .ram_wen    (ram_wen),
        .ram_load   (ram_load),
        .ram_ack    (ram_ack),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".i_ready"},   {31'd0, i_ready}, 32'd0);
        check({tag, ".d_ready"},   {31'd0, d_ready}, 32'd0);
        check({tag, ".ram_ren"},   {31'd0, ram_ren}, 32'd0);
        check({tag, ".ram_wen"},   {31'd0, ram_wen}, 32'd0);
        check({tag, ".ram_addr"},  ram_addr, 32'd0);
        check({tag, ".ram_store"}, ram_store, 32'd0);
        check({tag, ".bus_err"},   {31'd0, bus_err}, 32'd0);
    endtask

    // Runs a data read already sitting in its first access cycle; ack is high
    // only in access cycle ack_cyc (0 = never). Returns the cycle d_ready shows.
    task automatic run_read(input int ack_cyc, output int lat, output logic err);
        lat = 0;
        err = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (d_ready) begin
                lat = c;
                err = bus_err;
                break;
            end
            ram_ack = (c == ack_cyc);
            tick();
        end
        ram_ack = 1'b0;
    endtask

    initial begin
        int          lat;
        logic        err;
        int          k;
        logic [31:0] exp_word;

        nRST = 1'b0; imem_req = 1'b0; imem_addr = '0;
        dmem_ren = 1'b0; dmem_wen = 1'b0; dmem_addr = '0; dmem_store = '0;
        ram_load = '0; ram_ack = 1'b0;

        // Reset state
        tick(); tick();
        check_quiet("reset");
        check("reset.imem_load", imem_load, 32'd0);
        check("reset.dmem_load", dmem_load, 32'd0);

        // Reset in the middle of a fetch
        nRST = 1'b1; imem_req = 1'b1; imem_addr = 32'h10;
        tick();
        check("rstmid.ram_ren", {31'd0, ram_ren}, 32'd1);
        check("rstmid.ram_addr", ram_addr, 32'h10);
        imem_req = 1'b0;
        tick(); tick();
        nRST = 1'b0;
        tick();
        check_quiet("rstmid.after");
        nRST = 1'b1;
        tick();
        check("rstmid.no_ready", {31'd0, i_ready}, 32'd0);
        check("rstmid.idle_ren", {31'd0, ram_ren}, 32'd0);

        // Zero-wait fetch
        imem_req = 1'b1; imem_addr = 32'h40; ram_ack = 1'b1; ram_load = 32'h00500093;
        tick();
        check("fetch.ram_ren", {31'd0, ram_ren}, 32'd1);
        check("fetch.ram_addr", ram_addr, 32'h40);
        check("fetch.early_ready", {31'd0, i_ready}, 32'd0);
        tick();
        check("fetch.i_ready", {31'd0, i_ready}, 32'd1);
        check("fetch.imem_load", imem_load, 32'h00500093);
        check("fetch.resp_ren", {31'd0, ram_ren}, 32'd0);
        imem_req = 1'b0; ram_load = 32'h11111111;
        tick();
        check("fetch.pulse_end", {31'd0, i_ready}, 32'd0);
        check("fetch.held", imem_load, 32'h00500093);

        // Simultaneous write and fetch: write served first
        imem_req = 1'b1; imem_addr = 32'h44;
        dmem_wen = 1'b1; dmem_addr = 32'h1000; dmem_store = 32'hDEADBEEF;
        ram_ack = 1'b1; ram_load = 32'hCAFEF00D;
        tick();
        check("prio.ram_wen", {31'd0, ram_wen}, 32'd1);
        check("prio.ram_ren", {31'd0, ram_ren}, 32'd0);
        check("prio.ram_addr", ram_addr, 32'h1000);
        check("prio.ram_store", ram_store, 32'hDEADBEEF);
        tick();
        check("prio.d_ready", {31'd0, d_ready}, 32'd1);
        check("prio.i_ready", {31'd0, i_ready}, 32'd0);
        check("prio.dmem_load", dmem_load, 32'd0);
        dmem_wen = 1'b0;
        tick();
        check("prio.idle_ren", {31'd0, ram_ren}, 32'd0);
        tick();
        check("prio.fetch_ren", {31'd0, ram_ren}, 32'd1);
        check("prio.fetch_addr", ram_addr, 32'h44);
        tick();
        check("prio.fetch_ready", {31'd0, i_ready}, 32'd1);
        check("prio.imem_load", imem_load, 32'hCAFEF00D);
        imem_req = 1'b0; ram_ack = 1'b0;
        tick();

        // Data read with four wait states
        dmem_ren = 1'b1; dmem_addr = 32'h2000; ram_load = 32'h12345678;
        tick();
        check("wait.ram_ren", {31'd0, ram_ren}, 32'd1);
        check("wait.ram_addr", ram_addr, 32'h2000);
        dmem_ren = 1'b0;
        run_read(5, lat, err);
        check("wait.latency", lat, 32'd6);
        check("wait.bus_err", {31'd0, err}, 32'd0);
        check("wait.dmem_load", dmem_load, 32'h12345678);
        tick();

`ifdef REQ_TIMEOUT_EN
        // Access that never gets an ack
        dmem_ren = 1'b1; dmem_addr = 32'h3000; ram_load = 32'hFFFFFFFF;
        tick();
        dmem_ren = 1'b0;
        run_read(0, lat, err);
        check("tmo.latency", lat, 32'd10);
        check("tmo.bus_err", {31'd0, err}, 32'd1);
        check("tmo.ram_ren", {31'd0, ram_ren}, 32'd0);
        check("tmo.dmem_load", dmem_load, 32'd0);
        tick();
        check("tmo.err_end", {31'd0, bus_err}, 32'd0);

        // Ack on the limit cycle completes normally
        dmem_ren = 1'b1; ram_load = 32'hAAAA5555;
        tick();
        dmem_ren = 1'b0;
        run_read(9, lat, err);
        check("tmo_ack.latency", lat, 32'd10);
        check("tmo_ack.bus_err", {31'd0, err}, 32'd0);
        check("tmo_ack.dmem_load", dmem_load, 32'hAAAA5555);
        tick();
`endif

        // Back-to-back fetches with the request held
        k = 0; imem_req = 1'b1; imem_addr = 32'h0; ram_ack = 1'b1;
        for (int c = 1; c <= 15 && k < 3; c++) begin
            tick();
            ram_load = {16'hA5A5, ram_addr[15:0]};
            if (i_ready) begin
                exp_word = 32'hA5A50000 + 32'(4 * k);
                check("b2b.cycle", c, 32'(2 + 3 * k));
                check("b2b.data", imem_load, exp_word);
                k++;
                imem_addr = 32'(4 * k);
                if (k == 3) imem_req = 1'b0;
            end
        end
        check("b2b.count", k, 32'd3);
        ram_ack = 1'b0;
        tick();
        check_quiet("final");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/request_unit.md
# request_unit

Parametrised memory request unit that arbitrates the core's instruction-fetch and data-access ports onto one shared RAM port. It sits between the single-cycle datapath (PC/fetch and load/store paths) and the RAM. It replaces the hard-wired `i_ready = 1` path with a real ready handshake. Data accesses have priority over fetches, and responses are registered and held.

## Interface
Parameters:
- `ADDR_W`, 32, address width of all ports.
- `DATA_W`, 32, data width of all ports.
- `TIMEOUT`, 64, cycles without `ram_ack` before abort (used only with `REQ_TIMEOUT_EN`); must be ≥1.

Ports:
- `clk` in 1: the only clock; all state updates on its rising edge.
- `nRST` in 1: synchronous, active-low reset, sampled on `clk` rising edge.
- `imem_req` in 1: instruction fetch request; held until `i_ready`.
- `imem_addr` in ADDR_W: fetch address.
- `imem_load` out DATA_W: fetched instruction; registered, held until the next fetch completes.
- `i_ready` out 1: one-cycle pulse; `imem_load` is valid.
- `dmem_ren` / `dmem_wen` in 1: data read / write request; held until `d_ready`.
- `dmem_addr` in ADDR_W: data address.
- `dmem_store` in DATA_W: write data.
- `dmem_load` out DATA_W: read data; registered, held until the next data read completes.
- `d_ready` out 1: one-cycle pulse; data access complete.
- `ram_addr` out ADDR_W: RAM address.
- `ram_store` out DATA_W: RAM write data.
- `ram_ren` / `ram_wen` out 1: RAM strobes, held for the whole access.
- `ram_load` in DATA_W: RAM read data; valid when `ram_ack` is high.
- `ram_ack` in 1: RAM completion.
- `bus_err` out 1: one-cycle pulse with `i_ready`/`d_ready` on timeout abort; constant 0 when `REQ_TIMEOUT_EN` is not defined.

## Operation
- States:
  - IDLE, IFETCH, DACCESS, RESP.
  - Encoding is free; the reset state is IDLE.
- IDLE:
  - If `dmem_wen` or `dmem_ren` is high: latch address, store data and direction, then go to DACCESS.
  - Otherwise, if `imem_req` is high: latch `imem_addr`, then go to IFETCH.
  - Otherwise stay in IDLE.
- Priority:
  - Data wins over fetch when both are pending.
  - `dmem_wen` wins over `dmem_ren` if both are high (illegal stimulus, defined anyway).
- IFETCH and DACCESS:
  - Drive `ram_addr` from the latched address; `ram_store` from the latched data (writes only).
  - Assert exactly one of `ram_ren`/`ram_wen`.
  - Inputs on the requester side are ignored while in these states.
  - On `ram_ack`: capture `ram_load` into `imem_load` (fetch) or `dmem_load` (data read only), then go to RESP.
  - Data writes leave `dmem_load` unchanged.
- RESP:
  - Pulse `i_ready` or `d_ready` for this one cycle, then go to IDLE.
  - A request still high in the cycle after RESP is treated as a new request.
- RAM strobes, `ram_addr` and `ram_store` are 0 in IDLE and RESP.
- Only one RAM access is outstanding at a time; there is no pipelining.

## Timing
- Reset values: all outputs 0, `imem_load`/`dmem_load` 0, state IDLE.
- Reset mid-access drops the transaction: no ready pulse, and the strobes go low on the next cycle.
- Latency: request sampled at edge N; strobes high in cycle N+1.
  - With `ram_ack` in cycle N+1, ready is high in cycle N+2.
  - Minimum request-to-ready latency is 2 cycles.
  - Each extra wait cycle on `ram_ack` adds 1 cycle.
- Back-to-back: a new request sampled in the IDLE cycle after RESP gives a throughput of 1 access per 3 cycles with zero-wait RAM.
- A `ram_ack` seen in IDLE or RESP is ignored.

## Configuration
- `REQ_TIMEOUT_EN` defined:
  - A wait counter clears on entry to IFETCH/DACCESS and increments each cycle without `ram_ack`.
  - In a cycle where the counter equals `TIMEOUT` without `ram_ack`: drop the strobes and go to RESP.
  - In that RESP cycle pulse the matching ready together with `bus_err`.
  - The matching load register is set to all-zeros (reads only).
  - If `ram_ack` arrives in the same cycle the limit is reached, the ack wins and there is no error.
- `REQ_TIMEOUT_EN` not defined:
  - No counter; waits indefinitely.
  - `bus_err` is tied to 0.

## Test plan
- Reset mid-access: hold `nRST`=0 for 2 cycles, then `imem_req`=1, `imem_addr`=0x10, `ram_ack` held low 3 cycles, then `nRST`=0 for 1 cycle → no `i_ready`; all outputs 0 on the cycle after the reset edge; state is IDLE.
- Fetch, zero-wait: `imem_req`=1, `imem_addr`=0x40, `ram_ack`=1 with `ram_load`=0x00500093 → `ram_ren`=1 and `ram_addr`=0x40 in cycle 1; `i_ready` in cycle 2; `imem_load`=0x00500093 and held afterwards.
- Priority: `imem_req`=1 (0x44) and `dmem_wen`=1 (0x1000, store 0xDEADBEEF) in the same cycle → the write is served first (`ram_wen`, `d_ready`); the fetch of 0x44 follows and `i_ready` is issued later; `dmem_load` is unchanged.
- Wait states: data read 0x2000 with `ram_ack` delayed 4 cycles and `ram_load`=0x12345678 → `d_ready` arrives exactly 4 cycles after the zero-wait case; `dmem_load`=0x12345678.
- Timeout (`REQ_TIMEOUT_EN`, `TIMEOUT`=8): data read, `ram_ack` never asserted → strobes drop; `d_ready` and `bus_err` pulse together; `dmem_load`=0. Repeat with `ram_ack` arriving on the limit cycle → normal completion with `bus_err`=0.
- Back-to-back: 3 fetches to 0x0, 0x4, 0x8 with zero-wait RAM and the request held → `i_ready` pulses every 3 cycles with correct data in order.
